hc_scrub_ctrl: RTL and testbench

Memory scrub controller for Hamming-protected storage. On command it walks every word of a single-port RAM holding DATA_WD+CHK_WD-bit Hamming codewords. It sequences each word through the existing hc_dec decoder and hc_enc encoder, and writes the re-encoded word back only when the decoder flags an error. It yields the RAM to a host port whenever the host requests it, and reports error statistics.

---
 rtl/hc_scrub_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hc_scrub_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_scrub_ctrl.sv
`timescale 1ns/1ps
// hc_scrub_ctrl: background scrubber for a single-port RAM of Hamming codewords.
// Walks addresses 0..2**ADDR_WD-1. Each word is read, run through the external
// hc_dec/hc_enc pair, and written back only if the decoder flags an error.
// The host always has priority on the RAM.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_start                         scan start pulse, honoured only in IDLE
//   i_host_req/i_host_we/i_host_addr host access sideband (priority, collision)
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata   RAM port
//   o_dec_enc_data, i_dec_err_flag, i_dec_data               hc_dec hookup
//   o_enc_data_in, i_enc_data                                hc_enc hookup
//   o_busy, o_done, o_err_cnt, o_last_err_addr               status
module hc_scrub_ctrl #(
    parameter int unsigned DATA_WD = 4,
    parameter int unsigned CHK_WD  = 3,
    parameter int unsigned ADDR_WD = 4,
    parameter int unsigned CNT_WD  = 8,
    localparam int unsigned CW     = DATA_WD + CHK_WD
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_host_req,
    input  logic               i_host_we,
    input  logic [ADDR_WD-1:0] i_host_addr,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic [ADDR_WD-1:0] o_mem_addr,
    output logic [CW-1:0]      o_mem_wdata,
    input  logic [CW-1:0]      i_mem_rdata,
    output logic [CW-1:0]      o_dec_enc_data,
    input  logic               i_dec_err_flag,
    input  logic [DATA_WD-1:0] i_dec_data,
    output logic [DATA_WD-1:0] o_enc_data_in,
    input  logic [CW-1:0]      i_enc_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_WD-1:0]  o_err_cnt,
    output logic [ADDR_WD-1:0] o_last_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [CW-1:0]      cw_q, cw_d;
    logic [CW-1:0]      wdata_q, wdata_d;
    logic [CNT_WD-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_WD-1:0] last_err_q, last_err_d;
    logic               cancel_q, cancel_d;
    logic               host_hit_c;
    logic               mem_en_c, mem_we_c;

    // Host write to the word currently being scrubbed; invalidates our write-back.
    assign host_hit_c = i_host_req && i_host_we && (i_host_addr == addr_q) &&
                        ((state_q == S_WAIT) || (state_q == S_CHECK) || (state_q == S_WRITE));

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cw_q       <= '0;
            wdata_q    <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cw_q       <= cw_d;
            wdata_q    <= wdata_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
            cancel_q   <= cancel_d;
        end
    end

    // Next-state and RAM strobe logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cw_d       = cw_q;
        wdata_d    = wdata_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        cancel_d   = cancel_q || host_hit_c;
        mem_en_c   = 1'b0;
        mem_we_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (i_start) begin
                    addr_d     = '0;
                    err_cnt_d  = '0;
                    last_err_d = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                cancel_d = 1'b0;
                if (!i_host_req) begin
                    mem_en_c = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data is valid now regardless of host activity.
                cw_d    = i_mem_rdata;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (i_dec_err_flag) begin
                    if (err_cnt_q != {CNT_WD{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_WD'(1);
                    end
                    last_err_d = addr_q;
                    wdata_d    = i_enc_data;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WRITE: begin
                if (cancel_q || host_hit_c) begin
                    state_d = S_NEXT;
                end else if (!i_host_req) begin
                    mem_en_c = 1'b1;
                    mem_we_c = 1'b1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_q == {ADDR_WD{1'b1}}) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_WD'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_mem_en        = mem_en_c;
    assign o_mem_we        = mem_we_c;
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_dec_enc_data  = cw_q;
    assign o_enc_data_in   = i_dec_data;
    assign o_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done          = (state_q == S_DONE);
    assign o_err_cnt       = err_cnt_q;
    assign o_last_err_addr = last_err_q;

endmodule

// File: tb/tb_hc_scrub_ctrl.sv
`timescale 1ns/1ps
// Bench for hc_scrub_ctrl: behavioural RAM plus Hamming(7,4) enc/dec models,
// write-back scoreboard, scan timing and status checks.
module tb_hc_scrub_ctrl;

    localparam int unsigned DATA_WD = 4;
    localparam int unsigned CHK_WD  = 3;
    localparam int unsigned ADDR_WD = 4;
    localparam int unsigned CNT_WD  = 2;
    localparam int unsigned CW      = DATA_WD + CHK_WD;
    localparam int unsigned DEPTH   = 1 << ADDR_WD;

    typedef struct packed {
        logic [ADDR_WD-1:0] addr;
        logic [CW-1:0]      data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic host_req = 1'b0;
    logic host_we = 1'b0;
    logic [ADDR_WD-1:0] host_addr = '0;
    logic [CW-1:0]      host_wdata = '0;

    logic               mem_en, mem_we;
    logic [ADDR_WD-1:0] mem_addr;
    logic [CW-1:0]      mem_wdata;
    logic [CW-1:0]      mem_rdata = '0;
    logic [CW-1:0]      dut_cw;
    logic               dec_err;
    logic [DATA_WD-1:0] dec_data;
    logic [DATA_WD-1:0] enc_in;
    logic [CW-1:0]      enc_cw;
    logic               busy, done;
    logic [CNT_WD-1:0]  err_cnt;
    logic [ADDR_WD-1:0] last_err;

    logic [CW-1:0]      ram [DEPTH];
    logic [DATA_WD-1:0] gold [DEPTH];
    wr_t                exp_wr [$];
    wr_t                mon_e;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int scan_base = 0;
    int h_from = 1000;
    int h_to = -1;
    logic               h_we = 1'b0;
    logic [ADDR_WD-1:0] h_addr = '0;
    logic [CW-1:0]      h_wdata = '0;
    int hcur;
    bit first_rd = 1'b0;

    // Codeword layout {d3,d2,d1,d0,p2,p1,p0}
    function automatic logic [6:0] ham_enc(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[1] ^ d[3];
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[1] ^ d[2] ^ d[3];
        return {d, p2, p1, p0};
    endfunction

    function automatic logic [4:0] ham_dec(input logic [6:0] c);
        logic [3:0] d;
        logic [2:0] s;
        d = c[6:3];
        s[0] = c[0] ^ d[0] ^ d[1] ^ d[3];
        s[1] = c[1] ^ d[0] ^ d[2] ^ d[3];
        s[2] = c[2] ^ d[1] ^ d[2] ^ d[3];
        case (s)
            3'b011:  d[0] = ~d[0];
            3'b101:  d[1] = ~d[1];
            3'b110:  d[2] = ~d[2];
            3'b111:  d[3] = ~d[3];
            default: ;
        endcase
        return {(s != 3'b000), d};
    endfunction

    assign {dec_err, dec_data} = ham_dec(dut_cw);
    assign enc_cw = ham_enc(enc_in);

    hc_scrub_ctrl #(
        .DATA_WD (DATA_WD),
        .CHK_WD  (CHK_WD),
        .ADDR_WD (ADDR_WD),
        .CNT_WD  (CNT_WD)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_host_req      (host_req),
        .i_host_we       (host_we),
        .i_host_addr     (host_addr),
        .o_mem_en        (mem_en),
        .o_mem_we        (mem_we),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata),
        .o_dec_enc_data  (dut_cw),
        .i_dec_err_flag  (dec_err),
        .i_dec_data      (dec_data),
        .o_enc_data_in   (enc_in),
        .i_enc_data      (enc_cw),
        .o_busy          (busy),
        .o_done          (done),
        .o_err_cnt       (err_cnt),
        .o_last_err_addr (last_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, host has priority, registered read data
    always @(posedge clk) begin
        if (host_req && host_we) begin
            ram[host_addr] <= host_wdata;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Host driver: active over a window of scan cycles
    always @(posedge clk) begin
        #1;
        hcur       = cyc - scan_base;
        host_req   = (hcur >= h_from) && (hcur <= h_to);
        host_we    = host_req && h_we;
        host_addr  = h_addr;
        host_wdata = h_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard and RAM-port monitor
    always @(negedge clk) begin
        if (host_req) check_eq("mem_en_gated", 32'(mem_en), 32'd0);
        if (mem_en && mem_we) begin
            check_eq("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                mon_e = exp_wr.pop_front();
                check_eq("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check_eq("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
        if (mem_en && !mem_we && first_rd) begin
            check_eq("first_rd_addr", 32'(mem_addr), 32'd0);
            first_rd = 1'b0;
        end
    end

    task automatic fill_ram();
        for (int i = 0; i < int'(DEPTH); i++) ram[i] <= ham_enc(gold[i]);
        @(posedge clk);
    endtask

    task automatic corrupt(input int a, input int b);
        wr_t e;
        ram[a] <= ham_enc(gold[a]) ^ (7'(1) << b);
        e.addr = ADDR_WD'(a);
        e.data = ham_enc(gold[a]);
        exp_wr.push_back(e);
    endtask

    task automatic start_scan();
        @(posedge clk);
        #1;
        scan_base = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                n = cyc - scan_base;
            end
        end
        check_eq({tag, "_done_cyc"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_cyc));
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_ram_clean(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ham_enc(gold[i])) nbad++;
        check_eq({tag, "_ram_clean"}, 32'(nbad), 32'd0);
        check_eq({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic check_zero_outs(input string tag);
        check_eq({tag, "_mem_en"},   32'(mem_en),    32'd0);
        check_eq({tag, "_mem_we"},   32'(mem_we),    32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr),  32'd0);
        check_eq({tag, "_wdata"},    32'(mem_wdata), 32'd0);
        check_eq({tag, "_cw"},       32'(dut_cw),    32'd0);
        check_eq({tag, "_busy"},     32'(busy),      32'd0);
        check_eq({tag, "_done"},     32'(done),      32'd0);
        check_eq({tag, "_err_cnt"},  32'(err_cnt),   32'd0);
        check_eq({tag, "_last_err"}, 32'(last_err),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) gold[i] = 4'((i * 7 + 3) & 15);
        fill_ram();
        @(negedge clk);
        check_zero_outs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: all clean
        start_scan();
        @(negedge clk);
        check_eq("t1_busy_c1", 32'(busy), 32'd1);
        wait_done("t1", 65);
        check_eq("t1_err_cnt", 32'(err_cnt), 32'd0);
        check_ram_clean("t1");

        // 2: single corrected word
        corrupt(5, 3);
        start_scan();
        wait_done("t2", 66);
        check_eq("t2_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("t2_last_err", 32'(last_err), 32'd5);
        check_ram_clean("t2");

        // 3: host stall during READ of address 2
        h_from = 9; h_to = 11; h_we = 1'b0; h_addr = 4'd9;
        start_scan();
        wait_done("t3", 68);
        h_from = 1000; h_to = -1;
        check_ram_clean("t3");

        // 4: host write to the flagged word during CHECK cancels write-back
        ram[7] <= ham_enc(gold[7]) ^ 7'b0100000;
        h_from = 31; h_to = 31; h_we = 1'b1; h_addr = 4'd7; h_wdata = ham_enc(4'h9);
        start_scan();
        wait_done("t4", 66);
        h_from = 1000; h_to = -1; h_we = 1'b0;
        check_eq("t4_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("t4_last_err", 32'(last_err), 32'd7);
        check_eq("t4_host_val", 32'(ram[7]), 32'(ham_enc(4'h9)));
        gold[7] = 4'h9;
        check_ram_clean("t4");

        // 5: reset in cycle 30, then a fresh scan
        corrupt(3, 0);
        start_scan();
        while (cyc - scan_base < 30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero_outs("t5_rst");
        repeat (2) begin
            @(negedge clk);
            check_eq("t5_en_in_rst", 32'(mem_en), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_ram_clean("t5a");
        first_rd = 1'b1;
        start_scan();
        wait_done("t5", 65);
        check_eq("t5_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("t5_first_rd_seen", 32'(first_rd), 32'd0);

        // 6: five errors saturate a 2-bit counter, all still written back
        corrupt(1, 0);
        corrupt(4, 6);
        corrupt(8, 2);
        corrupt(12, 4);
        corrupt(15, 1);
        start_scan();
        wait_done("t6", 70);
        check_eq("t6_err_cnt", 32'(err_cnt), 32'd3);
        check_eq("t6_last_err", 32'(last_err), 32'd15);
        @(negedge clk);
        check_eq("t6_done_1cyc", 32'(done), 32'd0);
        check_eq("t6_err_hold", 32'(err_cnt), 32'd3);
        check_eq("t6_last_hold", 32'(last_err), 32'd15);
        check_ram_clean("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
